// File: rtl/fetch_stage_pipe.sv
// Y86-64 fetch stage: F register, PC select, byte-wide instruction memory and field split.
// Optional macro FETCH_STATS_EN adds saturating fetch_count/redirect_count outputs.
module fetch_stage_pipe #(
   parameter int unsigned IMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        F_stall,
   input  logic [3:0]  M_icode,
   input  logic        M_Cnd,
   input  logic [63:0] M_valA,
   input  logic [3:0]  W_icode,
   input  logic [63:0] W_valM,
   input  logic        imem_we,
   input  logic [63:0] imem_addr,
   input  logic [7:0]  imem_wdata,
   output logic [63:0] f_pc,
   output logic [63:0] f_predPC,
   output logic [3:0]  f_stat,
   output logic [3:0]  f_icode,
   output logic [3:0]  f_ifun,
   output logic [3:0]  f_rA,
   output logic [3:0]  f_rB,
   output logic [63:0] f_valC,
   output logic [63:0] f_valP
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] redirect_count
`endif
);

   localparam int unsigned AW = $clog2(IMEM_BYTES);

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] S_AOK = 4'b1000;
   localparam logic [3:0] S_HLT = 4'b0100;
   localparam logic [3:0] S_ADR = 4'b0010;
   localparam logic [3:0] S_INS = 4'b0001;

   logic [7:0]  mem [IMEM_BYTES];
   logic [63:0] F_predPC;
   logic [63:0] pc_sel;
   logic        mispredict;
   logic        ret_redirect;
   logic [7:0]  ibyte [10];
   logic [9:0]  byte_ok;
   logic [3:0]  icode_raw;
   logic [3:0]  ifun_raw;
   logic [3:0]  len;
   logic        need_regs;
   logic        need_valc;
   logic        icode_ok;
   logic        ifun_ok;
   logic        adr;
   logic [63:0] valc_raw;
   logic [63:0] pc_inc;
   logic [63:0] pc_len;

   always_ff @(posedge clk) begin
      if (imem_we && (imem_addr < 64'(IMEM_BYTES))) begin
         mem[imem_addr[AW-1:0]] <= imem_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         F_predPC <= 64'd0;
      end else if (!F_stall) begin
         F_predPC <= f_predPC;
      end
   end

   assign mispredict   = (M_icode == I_JXX) && !M_Cnd;
   assign ret_redirect = (W_icode == I_RET);

   always_comb begin
      if (mispredict) begin
         pc_sel = M_valA;
      end else if (ret_redirect) begin
         pc_sel = W_valM;
      end else begin
         pc_sel = F_predPC;
      end
   end

   // Carry out of pc+k counts as out of range so wrap-around reports ADR.
   always_comb begin
      logic [64:0] sum;
      sum = 65'd0;
      for (int k = 0; k < 10; k++) begin
         sum        = {1'b0, pc_sel} + 65'(k);
         byte_ok[k] = !sum[64] && (sum[63:0] < 64'(IMEM_BYTES));
         ibyte[k]   = byte_ok[k] ? mem[sum[AW-1:0]] : 8'h00;
      end
   end

   assign icode_raw = ibyte[0][7:4];
   assign ifun_raw  = ibyte[0][3:0];

   always_comb begin
      len       = 4'd1;
      need_regs = 1'b0;
      need_valc = 1'b0;
      icode_ok  = 1'b1;
      ifun_ok   = (ifun_raw == 4'h0);
      case (icode_raw)
         I_HALT, I_NOP, I_RET: len = 4'd1;
         I_RRMOVQ: begin
            len       = 4'd2;
            need_regs = 1'b1;
            ifun_ok   = (ifun_raw <= 4'd6);
         end
         I_OPQ: begin
            len       = 4'd2;
            need_regs = 1'b1;
            ifun_ok   = (ifun_raw <= 4'd3);
         end
         I_PUSHQ, I_POPQ: begin
            len       = 4'd2;
            need_regs = 1'b1;
         end
         I_JXX: begin
            len       = 4'd9;
            need_valc = 1'b1;
            ifun_ok   = (ifun_raw <= 4'd6);
         end
         I_CALL: begin
            len       = 4'd9;
            need_valc = 1'b1;
         end
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
            len       = 4'd10;
            need_regs = 1'b1;
            need_valc = 1'b1;
         end
         default: icode_ok = 1'b0;
      endcase
   end

   always_comb begin
      adr = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if ((4'(k) < len) && !byte_ok[k]) begin
            adr = 1'b1;
         end
      end
   end

   // valC follows the register byte when one is present.
   always_comb begin
      valc_raw = 64'd0;
      for (int j = 0; j < 8; j++) begin
         valc_raw[8*j +: 8] = need_regs ? ibyte[j+2] : ibyte[j+1];
      end
   end

   assign pc_inc = pc_sel + 64'd1;
   assign pc_len = pc_sel + {60'd0, len};

   always_comb begin
      f_pc     = pc_sel;
      f_stat   = S_AOK;
      f_icode  = I_NOP;
      f_ifun   = 4'h0;
      f_rA     = 4'hF;
      f_rB     = 4'hF;
      f_valC   = 64'd0;
      f_valP   = pc_inc;
      f_predPC = pc_inc;
      if (reset) begin
         f_pc     = 64'd0;
         f_valP   = 64'd0;
         f_predPC = 64'd0;
      end else if (adr) begin
         f_stat = S_ADR;
      end else if (!icode_ok || !ifun_ok) begin
         f_stat  = S_INS;
         f_icode = icode_raw;
      end else begin
         f_stat  = (icode_raw == I_HALT) ? S_HLT : S_AOK;
         f_icode = icode_raw;
         f_ifun  = ifun_raw;
         if (need_regs) begin
            f_rA = ibyte[1][7:4];
            f_rB = ibyte[1][3:0];
         end
         if (need_valc) begin
            f_valC = valc_raw;
         end
         f_valP   = pc_len;
         f_predPC = ((icode_raw == I_JXX) || (icode_raw == I_CALL)) ? valc_raw : pc_len;
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count    <= 32'd0;
         redirect_count <= 32'd0;
      end else begin
         if (!F_stall && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if ((mispredict || ret_redirect) && (redirect_count != 32'hFFFF_FFFF)) begin
            redirect_count <= redirect_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage_pipe.sv
// Bench for fetch_stage_pipe: vector table through an expected-output queue,
// plus hand sequences for memory writes and mid-run reset.
module tb_fetch_stage_pipe;

   logic        clk;
   logic        reset;
   logic        F_stall;
   logic [3:0]  M_icode;
   logic        M_Cnd;
   logic [63:0] M_valA;
   logic [3:0]  W_icode;
   logic [63:0] W_valM;
   logic        imem_we;
   logic [63:0] imem_addr;
   logic [7:0]  imem_wdata;
   logic [63:0] f_pc;
   logic [63:0] f_predPC;
   logic [3:0]  f_stat;
   logic [3:0]  f_icode;
   logic [3:0]  f_ifun;
   logic [3:0]  f_rA;
   logic [3:0]  f_rB;
   logic [63:0] f_valC;
   logic [63:0] f_valP;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [31:0] redirect_count;
`endif

   fetch_stage_pipe #(.IMEM_BYTES(1024)) dut (
      .clk        (clk),
      .reset      (reset),
      .F_stall    (F_stall),
      .M_icode    (M_icode),
      .M_Cnd      (M_Cnd),
      .M_valA     (M_valA),
      .W_icode    (W_icode),
      .W_valM     (W_valM),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .f_pc       (f_pc),
      .f_predPC   (f_predPC),
      .f_stat     (f_stat),
      .f_icode    (f_icode),
      .f_ifun     (f_ifun),
      .f_rA       (f_rA),
      .f_rB       (f_rB),
      .f_valC     (f_valC),
      .f_valP     (f_valP)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count    (fetch_count),
      .redirect_count (redirect_count)
`endif
   );

   typedef struct {
      logic [63:0] pc;
      logic [63:0] pred;
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] valc;
      logic [63:0] valp;
   } exp_t;

   typedef struct {
      logic        stall;
      logic [3:0]  mi;
      logic        mc;
      logic [63:0] ma;
      logic [3:0]  wi;
      logic [63:0] wv;
      exp_t        e;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   vec_t vecs[17];
   exp_t bub;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic exp_t mkexp(input logic [63:0] pc, input logic [63:0] pred,
                                  input logic [3:0] stat, input logic [3:0] icode,
                                  input logic [3:0] ifun, input logic [3:0] ra,
                                  input logic [3:0] rb, input logic [63:0] valc,
                                  input logic [63:0] valp);
      exp_t e;
      e.pc = pc; e.pred = pred; e.stat = stat; e.icode = icode; e.ifun = ifun;
      e.ra = ra; e.rb = rb; e.valc = valc; e.valp = valp;
      return e;
   endfunction

   function automatic vec_t mkvec(input logic stall, input logic [3:0] mi, input logic mc,
                                  input logic [63:0] ma, input logic [3:0] wi,
                                  input logic [63:0] wv, input exp_t e);
      vec_t v;
      v.stall = stall; v.mi = mi; v.mc = mc; v.ma = ma; v.wi = wi; v.wv = wv; v.e = e;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input string fld, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %0h, expected %0h", tag, fld, act, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s.queue: got empty, expected an entry", tag);
      end else begin
         e = sb.pop_front();
         chk(tag, "pc", f_pc, e.pc);
         chk(tag, "predPC", f_predPC, e.pred);
         chk(tag, "stat", {60'd0, f_stat}, {60'd0, e.stat});
         chk(tag, "icode", {60'd0, f_icode}, {60'd0, e.icode});
         chk(tag, "ifun", {60'd0, f_ifun}, {60'd0, e.ifun});
         chk(tag, "rA", {60'd0, f_rA}, {60'd0, e.ra});
         chk(tag, "rB", {60'd0, f_rB}, {60'd0, e.rb});
         chk(tag, "valC", f_valC, e.valc);
         chk(tag, "valP", f_valP, e.valp);
      end
   endtask

   task automatic wr(input logic [63:0] addr, input logic [7:0] data);
      imem_we    = 1'b1;
      imem_addr  = addr;
      imem_wdata = data;
      tick();
      imem_we    = 1'b0;
   endtask

   // Bytes are left-aligned in 'seq': the first byte written is seq[79:72].
   task automatic load_seq(input logic [63:0] base, input logic [79:0] seq, input int n);
      for (int i = 0; i < n; i++) begin
         wr(base + 64'(i), seq[79-8*i -: 8]);
      end
   endtask

   task automatic drive(input logic stall, input logic [3:0] mi, input logic mc,
                        input logic [63:0] ma, input logic [3:0] wi, input logic [63:0] wv);
      F_stall = stall; M_icode = mi; M_Cnd = mc; M_valA = ma; W_icode = wi; W_valM = wv;
   endtask

   initial begin
      reset = 1'b1;
      imem_we = 1'b0; imem_addr = 64'd0; imem_wdata = 8'd0;
      drive(1'b0, 4'h0, 1'b0, 64'd0, 4'h0, 64'd0);
      bub = mkexp(64'd0, 64'd0, 4'b1000, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);

      // stall mi mc ma wi wv | pc pred stat icode ifun rA rB valC valP
      vecs[0]  = mkvec(0, 4'h0, 0, 0, 4'h0, 0,
                       mkexp(0, 10, 4'b1000, 4'h3, 4'h0, 4'hF, 4'h3, 109, 10));
      vecs[1]  = mkvec(0, 4'h0, 0, 0, 4'h0, 0,
                       mkexp(10, 12, 4'b1000, 4'h6, 4'h0, 4'h1, 4'h2, 0, 12));
      vecs[2]  = mkvec(0, 4'h0, 0, 0, 4'h0, 0,
                       mkexp(12, 64'h40, 4'b1000, 4'h7, 4'h4, 4'hF, 4'hF, 64'h40, 21));
      vecs[3]  = mkvec(0, 4'h7, 0, 21, 4'h9, 64'h100,
                       mkexp(21, 22, 4'b0001, 4'hC, 4'h0, 4'hF, 4'hF, 0, 22));
      vecs[4]  = mkvec(0, 4'h0, 0, 0, 4'h0, 0,
                       mkexp(22, 23, 4'b1000, 4'h1, 4'h0, 4'hF, 4'hF, 0, 23));
      vecs[5]  = mkvec(0, 4'h0, 0, 0, 4'h9, 64'h100,
                       mkexp(64'h100, 64'h102, 4'b1000, 4'h6, 4'h1, 4'h3, 4'h4, 0, 64'h102));
      vecs[6]  = mkvec(1, 4'h0, 0, 0, 4'h0, 0,
                       mkexp(64'h102, 64'h103, 4'b1000, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h103));
      vecs[7]  = mkvec(1, 4'h0, 0, 0, 4'h0, 0,
                       mkexp(64'h102, 64'h103, 4'b1000, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h103));
      vecs[8]  = mkvec(1, 4'h0, 0, 0, 4'h9, 64'h40,
                       mkexp(64'h40, 64'h41, 4'b0100, 4'h0, 4'h0, 4'hF, 4'hF, 0, 64'h41));
      vecs[9]  = mkvec(0, 4'h0, 0, 0, 4'h0, 0,
                       mkexp(64'h102, 64'h103, 4'b1000, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h103));
      vecs[10] = mkvec(0, 4'h0, 0, 0, 4'h0, 0,
                       mkexp(64'h103, 64'h40, 4'b1000, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h10C));
      vecs[11] = mkvec(0, 4'h0, 0, 0, 4'h9, 1020,
                       mkexp(1020, 1021, 4'b0010, 4'h1, 4'h0, 4'hF, 4'hF, 0, 1021));
      vecs[12] = mkvec(0, 4'h0, 0, 0, 4'h9, 64'h200,
                       mkexp(64'h200, 64'h201, 4'b0001, 4'h6, 4'h0, 4'hF, 4'hF, 0, 64'h201));
      vecs[13] = mkvec(0, 4'h0, 0, 0, 4'h9, 64'hFFFF_FFFF_FFFF_FFFF,
                       mkexp(64'hFFFF_FFFF_FFFF_FFFF, 0, 4'b0010, 4'h1, 4'h0, 4'hF, 4'hF, 0, 0));
      vecs[14] = mkvec(0, 4'h0, 0, 0, 4'h0, 0,
                       mkexp(0, 10, 4'b1000, 4'h3, 4'h0, 4'hF, 4'h3, 109, 10));
      vecs[15] = mkvec(0, 4'h7, 1, 21, 4'h0, 0,
                       mkexp(10, 12, 4'b1000, 4'h6, 4'h0, 4'h1, 4'h2, 0, 12));
      vecs[16] = mkvec(0, 4'h7, 0, 64'h40, 4'h0, 0,
                       mkexp(64'h40, 64'h41, 4'b0100, 4'h0, 4'h0, 4'hF, 4'hF, 0, 64'h41));

      #2;
      sb.push_back(bub);
      pop_check("reset_hold");

      load_seq(0,      80'h30F36D00000000000000, 10);
      load_seq(10,     80'h60120000000000000000, 2);
      load_seq(12,     80'h74400000000000000000, 9);
      load_seq(21,     80'hC0100000000000000000, 2);
      load_seq(64'h40, 80'h00000000000000000000, 1);
      load_seq(64'h100, 80'h61341070400000000000, 10);
      load_seq(64'h10A, 80'h00000000000000000000, 2);
      load_seq(1020,   80'h30F00000000000000000, 4);
      load_seq(64'h200, 80'h67120000000000000000, 2);

      reset = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].stall, vecs[i].mi, vecs[i].mc, vecs[i].ma, vecs[i].wi, vecs[i].wv);
         sb.push_back(vecs[i].e);
         #2;
         pop_check($sformatf("vec%0d", i));
         tick();
      end

      // Runtime write becomes visible next cycle; an out-of-range write must not alias.
      drive(1'b0, 4'h0, 1'b0, 64'd0, 4'h0, 64'd0);
      wr(64'h300, 8'h20);
      wr(64'h301, 8'hAB);
      wr(64'h700, 8'h00);
      drive(1'b0, 4'h0, 1'b0, 64'd0, 4'h9, 64'h300);
      sb.push_back(mkexp(64'h300, 64'h302, 4'b1000, 4'h2, 4'h0, 4'hA, 4'hB, 0, 64'h302));
      #2;
      pop_check("imem_write");
      tick();

      // Mid-run asynchronous reset while fetching at 0x40.
      drive(1'b0, 4'h7, 1'b0, 64'h40, 4'h0, 64'd0);
      sb.push_back(mkexp(64'h40, 64'h41, 4'b0100, 4'h0, 4'h0, 4'hF, 4'hF, 0, 64'h41));
      #2;
      pop_check("pre_reset");
      reset = 1'b1;
      #1;
      sb.push_back(bub);
      pop_check("async_reset");
      tick();
      drive(1'b0, 4'h0, 1'b0, 64'd0, 4'h0, 64'd0);
      reset = 1'b0;
      sb.push_back(mkexp(0, 10, 4'b1000, 4'h3, 4'h0, 4'hF, 4'h3, 109, 10));
      #2;
      pop_check("post_reset");
`ifdef FETCH_STATS_EN
      chk("post_reset", "fetch_count", {32'd0, fetch_count}, 64'd0);
      chk("post_reset", "redirect_count", {32'd0, redirect_count}, 64'd0);
`endif
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
